des_perm_unit: RTL and testbench
================================

DES_PERM_UNIT -- requirements
Module: des_perm_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in 64-bit words; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 16, width of the processed-block counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port set, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, a block is offered on data_in.
REQ-006 SHALL have port in_ready, output, 1, the unit accepts a block this cycle.
REQ-007 SHALL have port mode, input, 1, 0 = initial permutation IP, 1 = inverse IP (IP^-1); sampled with data_in.
REQ-008 SHALL have port data_in, input, [0:63], block in DES bit order, with bit 0 = DES bit 1 = MSB.
REQ-009 SHALL have port out_valid, output, 1, data_out holds a valid permuted block.
REQ-010 SHALL have port out_ready, input, 1, the consumer takes data_out this cycle.
REQ-011 SHALL have port data_out, output, [0:63], permuted block in DES bit order.
REQ-012 SHALL have port out_mode, output, 1, the mode used for the block on data_out.
REQ-013 SHALL have port status, output, 1, high when the unit is idle: stage empty and FIFO empty.
REQ-014 SHALL have port blk_count, output, CNT_W, number of blocks delivered on the output.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 An input transfer SHALL register the IP or IP^-1 of data_in (per the standard DES tables) and mode into a one-entry stage.
REQ-017 The stage SHALL move to the FIFO tail on the next edge when the FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-018 data_out, out_mode and out_valid SHALL be driven directly from the FIFO head; minimum latency from input transfer to out_valid is 2 cycles.
REQ-019 in_ready SHALL be high when the stage is empty, or when the stage will drain into the FIFO this cycle; it SHALL NOT combinationally depend on in_valid.
REQ-020 Simultaneous push and pop SHALL keep the occupancy unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 With the FIFO full and out_ready low, the stage SHALL hold its block, in_ready SHALL be low, and no block SHALL be lost or duplicated.
REQ-022 With the FIFO empty, out_valid SHALL be low and data_out SHALL hold its last value.
REQ-023 blk_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 Blocks SHALL leave in acceptance order; mode MAY change on every transfer.
REQ-025 status SHALL be combinational: !stage_valid && fifo_empty.

Reset
REQ-026 While set is high, all valid flags, pointers, the occupancy count and blk_count SHALL be 0, in_ready SHALL be 0, status SHALL be 1, and data_out SHALL be 64'h0.
REQ-027 Assertion of set mid-operation SHALL discard all buffered blocks immediately, regardless of clk.
REQ-028 in_ready SHALL rise on the first clk edge after set deasserts.

Structure
REQ-029 The IP and IP^-1 tables (64 entries of 1..64) and the permute function SHALL live in the shared package des_pkg, for reuse by the other DES blocks.
REQ-030 The FIFO SHALL be the sub-module des_blk_fifo, parameterised on width and depth, with push/pop/full/empty.
REQ-031 The permutation SHALL be a table-indexed loop, not a hand-expanded wiring list.

Verification
REQ-032 mode=0, data_in=64'h0123456789ABCDEF, out_ready=1 -> data_out=64'hCC00CCFFF0AAF0AA, out_mode=0, out_valid 2 cycles after acceptance, blk_count=1.
REQ-033 mode=1, data_in=64'hCC00CCFFF0AAF0AA -> data_out=64'h0123456789ABCDEF; random blocks sent as IP then IP^-1 SHALL round-trip to the original.
REQ-034 out_ready=0 with 6 blocks offered at FIFO_DEPTH=4 -> 5 accepted (4 in FIFO + 1 in stage) and in_ready low; after out_ready=1, all 5 leave in order.
REQ-035 FIFO kept full with in_valid=out_ready=1 continuously -> one block per cycle throughput, occupancy constant, pointers wrap correctly.
REQ-036 set pulsed mid-stream between clk edges -> out_valid=0, status=1 and blk_count=0 immediately; the first block after release emerges correctly.
REQ-037 CNT_W=4, 17 blocks delivered -> blk_count=1 (wrap).

Source files
------------

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES definitions: block type, permutation mode, the initial permutation
// (IP) and inverse initial permutation (IP^-1) tables, and a table-driven
// permute function. Bit numbering follows DES: index 0 of a des_blk_t is DES
// bit 1, the MSB. Table entries are 1-based source bit numbers, as printed in
// the DES standard.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int DES_W   = 64;
    localparam int ENTRY_W = DES_W + 1;   // mode bit + block, as stored in the FIFO

    typedef logic [0:DES_W-1] des_blk_t;
    typedef logic [6:0]       tbl_idx_t;  // holds 1..64

    typedef enum logic {
        PERM_IP     = 1'b0,
        PERM_IP_INV = 1'b1
    } perm_mode_e;

    localparam tbl_idx_t IP_TABLE [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam tbl_idx_t IP_INV_TABLE [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    // Output bit i takes input bit (table[i] - 1); the table is 1-based.
    function automatic des_blk_t des_permute(input des_blk_t din, input perm_mode_e sel);
        des_blk_t dout;
        tbl_idx_t src;
        logic [5:0] pos;
        dout = '0;
        for (int i = 0; i < DES_W; i++) begin
            pos = 6'(i);
            if (sel == PERM_IP_INV) begin
                src = IP_INV_TABLE[i];
            end else begin
                src = IP_TABLE[i];
            end
            dout[pos] = din[6'(src - 7'd1)];
        end
        return dout;
    endfunction

endpackage

// File: rtl/des_perm_unit_if.sv
// -----------------------------------------------------------------------------
// des_perm_unit_if
// Stream bundle of the permutation unit.
//   in_valid/in_ready/mode/data_in     : input block handshake
//   out_valid/out_ready/data_out/out_mode : output block handshake
//   status                             : unit idle (nothing buffered)
//   blk_count                          : blocks delivered, wraps
// master = block producer/consumer side, slave = the unit.
// -----------------------------------------------------------------------------
interface des_perm_unit_if
    import des_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic             mode;
    des_blk_t         data_in;
    logic             out_valid;
    logic             out_ready;
    des_blk_t         data_out;
    logic             out_mode;
    logic             status;
    logic [CNT_W-1:0] blk_count;

    modport master (
        output in_valid, mode, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_mode, status, blk_count
    );

    modport slave (
        input  in_valid, mode, data_in, out_ready,
        output in_ready, out_valid, data_out, out_mode, status, blk_count
    );

endinterface

// File: rtl/des_blk_fifo.sv
// -----------------------------------------------------------------------------
// des_blk_fifo
// Synchronous FIFO with show-ahead head. When empty, rdata keeps the last
// popped entry (zero after reset) instead of exposing stale storage.
//   clk, rst          : clock, asynchronous active-high reset
//   push, wdata, full : write side; push while full is taken only with a pop
//   pop, rdata, empty : read side; rdata is the head entry
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module des_blk_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] last_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Head selection: live entry when occupied, otherwise the last one popped.
    always_comb begin
        rdata = last_r;
        if (empty) begin
            rdata = last_r;
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    // Entry storage; contents are only observable through pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and last-popped holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            last_r   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                last_r   <= mem_r[rd_ptr_r];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/des_perm_unit.sv
// -----------------------------------------------------------------------------
// des_perm_unit
// Applies the DES initial permutation (mode 0) or its inverse (mode 1) to a
// stream of 64-bit blocks. Accepted blocks are permuted into a one-entry stage
// and then buffered in a FIFO whose head drives the output.
//   clk  : clock
//   set  : asynchronous active-high reset; discards all buffered blocks
//   bus  : stream bundle (des_perm_unit_if.slave)
// -----------------------------------------------------------------------------
module des_perm_unit
    import des_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          set,
    des_perm_unit_if.slave bus
);

    logic               run_r;        // holds in_ready low until the first edge after reset
    logic               stage_valid_r;
    des_blk_t           stage_data_r;
    logic               stage_mode_r;
    logic [CNT_W-1:0]   blk_count_r;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               pop_s;
    logic               drain_s;
    logic               in_ready_s;
    logic               accept_s;

    // Handshake decode; in_ready looks at out_ready but never at in_valid.
    always_comb begin
        pop_s      = !fifo_empty_s && bus.out_ready;
        drain_s    = stage_valid_r && (!fifo_full_s || pop_s);
        in_ready_s = run_r && (!stage_valid_r || drain_s);
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Stage register, ready enable and delivered-block counter.
    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            run_r         <= 1'b0;
            stage_valid_r <= 1'b0;
            stage_data_r  <= '0;
            stage_mode_r  <= 1'b0;
            blk_count_r   <= '0;
        end else begin
            run_r <= 1'b1;
            if (accept_s) begin
                stage_valid_r <= 1'b1;
                stage_data_r  <= des_permute(bus.data_in, perm_mode_e'(bus.mode));
                stage_mode_r  <= bus.mode;
            end else if (drain_s) begin
                stage_valid_r <= 1'b0;
            end else begin
                stage_valid_r <= stage_valid_r;
            end
            if (pop_s) begin
                blk_count_r <= blk_count_r + CNT_W'(1);
            end else begin
                blk_count_r <= blk_count_r;
            end
        end
    end

    des_blk_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (set),
        .push  (drain_s),
        .wdata ({stage_mode_r, stage_data_r}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.out_mode  = fifo_rdata_s[ENTRY_W-1];
    assign bus.data_out  = fifo_rdata_s[DES_W-1:0];
    assign bus.status    = !stage_valid_r && fifo_empty_s;
    assign bus.blk_count = blk_count_r;

endmodule

// File: tb/tb_des_perm_unit.sv
// -----------------------------------------------------------------------------
// tb_des_perm_unit
// Randomized, self-checking bench for des_perm_unit. A scoreboard built from a
// formula-based IP model (IP^-1 derived by inverting it) predicts every block
// leaving the unit; directed sequences cover latency, backpressure,
// throughput, mid-stream reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_des_perm_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic set;

    always #5 clk = ~clk;

    des_perm_unit_if #(.CNT_W(CW)) bus ();

    des_perm_unit #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .set (set),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] exp_q [$];
    int          exp_cnt = 0;

    // DES IP: row r of the printed table starts at 58,60,62,64,57,59,61,63
    // and each column steps down by 8.
    function automatic logic [0:63] ref_ip(input logic [0:63] x);
        logic [0:63] y;
        int r, c, s;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            s = ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
            y[i] = x[s - 1];
        end
        return y;
    endfunction

    // Inverse of the above: whatever IP moved to position i goes back.
    function automatic logic [0:63] ref_ipinv(input logic [0:63] x);
        logic [0:63] y;
        int r, c, s;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            s = ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
            y[s - 1] = x[i];
        end
        return y;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: sample handshakes at negedge; transfers happen at the next posedge.
    always @(negedge clk) begin
        logic [64:0] e;
        if (!set) begin
            chk("blk_count", 64'(bus.blk_count), 64'(exp_cnt % (1 << CW)));
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data_out", bus.data_out, e[63:0]);
                    chk("out_mode", 64'(bus.out_mode), 64'(e[64]));
                end
                exp_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({bus.mode, bus.mode ? ref_ipinv(bus.data_in) : ref_ip(bus.data_in)});
            end
        end
    end

    task automatic send_one(input logic m, input logic [0:63] d);
        logic ok;
        ok = 1'b0;
        bus.mode     = m;
        bus.data_in  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_out(output logic [0:63] d, output logic m);
        logic ok;
        ok = 1'b0;
        d  = '0;
        m  = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                d  = bus.data_out;
                m  = bus.out_mode;
            end
        end
        @(posedge clk);
        #1;
        chk("out_seen", 64'(ok), 64'd1);
    endtask

    task automatic stream(input int cycles, input int max_blk, output int acc, output int pops);
        logic a, p;
        acc = 0;
        pops = 0;
        bus.mode     = 1'($urandom_range(0, 1));
        bus.data_in  = rnd64();
        bus.in_valid = (max_blk > 0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            a = bus.in_valid && bus.in_ready;
            p = bus.out_valid && bus.out_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                bus.mode    = 1'($urandom_range(0, 1));
                bus.data_in = rnd64();
                if (acc >= max_blk) bus.in_valid = 1'b0;
            end
            if (p) pops++;
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.status) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("drain_idle", 64'(ok), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_status"},    64'(bus.status),    64'd1);
        chk({tag, "_blk_count"}, 64'(bus.blk_count), 64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        chk({tag, "_data_out"},  bus.data_out,       64'd0);
    endtask

    task automatic check_release(input string tag);
        @(negedge clk);
        chk({tag, "_ready_before_edge"}, 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_ready_after_edge"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [0:63] x, y, z;
        logic        m;
        int          acc, pops;

        set           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;

        // Reset state and release behaviour.
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        #1 set = 1'b0;
        check_release("rel");

        // Known IP vector, exact latency, first count.
        bus.out_ready = 1'b1;
        send_one(1'b0, 64'h0123456789ABCDEF);
        chk("lat_1cyc_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_2cyc_valid", 64'(bus.out_valid), 64'd1);
        chk("ip_vector",      bus.data_out, 64'hCC00CCFFF0AAF0AA);
        chk("ip_mode",        64'(bus.out_mode), 64'd0);
        @(posedge clk);
        #1;
        chk("first_count", 64'(bus.blk_count), 64'd1);
        chk("idle_after",  64'(bus.status),    64'd1);

        // Known IP^-1 vector.
        send_one(1'b1, 64'hCC00CCFFF0AAF0AA);
        wait_out(z, m);
        chk("ipinv_vector", z, 64'h0123456789ABCDEF);
        chk("ipinv_mode",   64'(m), 64'd1);

        // Random round trips through the unit.
        for (int k = 0; k < 4; k++) begin
            x = rnd64();
            send_one(1'b0, x);
            wait_out(y, m);
            send_one(1'b1, y);
            wait_out(z, m);
            chk("roundtrip", z, x);
        end

        // Backpressure: 6 offered, 5 fit (FIFO + stage).
        bus.out_ready = 1'b0;
        stream(12, 6, acc, pops);
        chk("bp_accepted",  64'(acc),           64'd5);
        chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_status",    64'(bus.status),    64'd0);
        drain();

        // Full FIFO with both sides open: one block per cycle.
        bus.out_ready = 1'b0;
        stream(10, 5, acc, pops);
        chk("tp_fill", 64'(acc), 64'd5);
        bus.out_ready = 1'b1;
        stream(20, 1000, acc, pops);
        chk("tp_accepts", 64'(acc), 64'd20);
        chk("tp_pops",    64'(pops), 64'd20);
        chk("tp_busy",    64'(bus.status), 64'd0);
        drain();

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.mode      = 1'($urandom_range(0, 1));
            bus.data_in   = rnd64();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Mid-stream reset pulse between edges, then counter wrap.
        for (int i = 0; i < 25; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.mode      = 1'($urandom_range(0, 1));
            bus.data_in   = rnd64();
            bus.out_ready = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #2 set = 1'b1;
        #1;
        check_reset_state("mid");
        exp_q.delete();
        exp_cnt = 0;
        bus.in_valid = 1'b0;
        #1 set = 1'b0;
        check_release("mid_rel");
        bus.out_ready = 1'b1;
        send_one(1'b0, 64'h0123456789ABCDEF);
        wait_out(z, m);
        chk("post_rst_block", z, 64'hCC00CCFFF0AAF0AA);
        for (int k = 0; k < 16; k++) begin
            send_one(1'($urandom_range(0, 1)), rnd64());
            wait_out(z, m);
        end
        chk("count_wrap", 64'(bus.blk_count), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
